// File: rtl/ccir656_pkg.sv
// Shared definitions for the BT.656 / CCIR656 generator and receiver:
// preamble bytes, XY bit layout, receiver FSM states and protection bits.
package ccir656_pkg;

  // Timing reference preamble: FF 00 00 XY
  localparam logic [7:0] PRE_FF = 8'hFF;
  localparam logic [7:0] PRE_00 = 8'h00;

  // XY byte layout: 1 F V H P3 P2 P1 P0
  localparam int XY_ONE_BIT  = 7;
  localparam int XY_F_BIT    = 6;
  localparam int XY_V_BIT    = 5;
  localparam int XY_H_BIT    = 4;
  localparam int XY_PROT_MSB = 3;

  // Named XY codes (SAV has H=0, EAV has H=1)
  localparam logic [7:0] XY_SAV_F0_V0 = 8'h80;
  localparam logic [7:0] XY_EAV_F0_V0 = 8'h9D;
  localparam logic [7:0] XY_SAV_F0_V1 = 8'hAB;
  localparam logic [7:0] XY_EAV_F0_V1 = 8'hB6;
  localparam logic [7:0] XY_SAV_F1_V0 = 8'hC7;
  localparam logic [7:0] XY_EAV_F1_V0 = 8'hDA;
  localparam logic [7:0] XY_SAV_F1_V1 = 8'hEC;
  localparam logic [7:0] XY_EAV_F1_V1 = 8'hF1;

  // Receiver preamble search / active region states
  typedef enum logic [2:0] {
    ST_SEARCH,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_ACTIVE
  } rx_state_t;

  // Protection bits {P3,P2,P1,P0} for a given F/V/H
  function automatic logic [3:0] xy_prot(input logic f, input logic v, input logic h);
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  // Full XY byte for a given F/V/H, as emitted by the generator
  function automatic logic [7:0] xy_code(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, xy_prot(f, v, h)};
  endfunction

endpackage

// File: rtl/ccir656_rx_if.sv
// Byte stream in, decoded pixel stream and status out.
// master: stream source / consumer side; slave: the receiver.
interface ccir656_rx_if;
  logic [7:0]  din;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic [10:0] sample_cnt;
  logic [9:0]  line_cnt;
  logic        field;
  logic        vblank;
  logic        hblank;
  logic        sav_pulse;
  logic        eav_pulse;
  logic        xy_err;
  logic        line_err;
  logic        locked;

  modport master (
    output din,
    input  pix_data, pix_valid, sample_cnt, line_cnt, field, vblank, hblank,
    input  sav_pulse, eav_pulse, xy_err, line_err, locked
  );

  modport slave (
    input  din,
    output pix_data, pix_valid, sample_cnt, line_cnt, field, vblank, hblank,
    output sav_pulse, eav_pulse, xy_err, line_err, locked
  );
endinterface

// File: rtl/ccir656_xy_check.sv
// Combinational XY decode: extracts F/V/H and flags a well-formed code
// (fixed 1 in bit 7 and matching protection bits).
module ccir656_xy_check
  import ccir656_pkg::*;
(
  input  logic [7:0] xy,
  output logic       f,
  output logic       v,
  output logic       h,
  output logic       ok
);

  assign f  = xy[XY_F_BIT];
  assign v  = xy[XY_V_BIT];
  assign h  = xy[XY_H_BIT];
  assign ok = xy[XY_ONE_BIT] && (xy[XY_PROT_MSB:0] == xy_prot(f, v, h));

endmodule

// File: rtl/ccir656_rx.sv
// BT.656 byte-stream receiver: finds FF 00 00 XY timing references,
// tracks F/V/H, outputs active bytes with indices and lock status.
// All outputs are registered and appear the cycle after the causing byte.
module ccir656_rx
  import ccir656_pkg::*;
#(
  parameter int ACTIVE_SAMPLES = 1440,
  parameter int LOCK_LINES     = 2
) (
  input logic         clk27M,
  input logic         rst,
  ccir656_rx_if.slave bus
);

  localparam int               LOCK_TARGET = 2 * LOCK_LINES;
  localparam int               LOCK_W      = $clog2(LOCK_TARGET + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX   = LOCK_W'(LOCK_TARGET);
  localparam logic [LOCK_W-1:0] LOCK_PRE   = LOCK_W'(LOCK_TARGET - 1);
  localparam logic [LOCK_W-1:0] LOCK_ONE   = LOCK_W'(1);
  localparam logic [10:0]       LAST_IDX   = 11'(ACTIVE_SAMPLES - 1);
  localparam logic [9:0]        LINE_MAX   = '1;

  // Everything the receiver remembers besides the FSM state
  typedef struct packed {
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic [10:0]       sample_cnt;
    logic [9:0]        line_cnt;
    logic              field;
    logic              vblank;
    logic              hblank;
    logic              sav_pulse;
    logic              eav_pulse;
    logic              xy_err;
    logic              line_err;
    logic              locked;
    logic [10:0]       act_idx;    // index of the next active byte
    logic              have_code;  // a valid code has been seen since reset
    logic              last_h;     // H of that last valid code
    logic [LOCK_W-1:0] lock_cnt;   // consecutive well-ordered codes
  } rx_regs_t;

  rx_state_t state_q, state_d;
  rx_regs_t  r_q, r_d;

  logic xy_f, xy_v, xy_h, xy_ok;
  logic code_ok;   // valid XY accepted this cycle
  logic seq_bad;   // valid code repeats the previous H
  logic ff_abort;  // FF found inside the active region

  ccir656_xy_check u_xy_check (
    .xy (bus.din),
    .f  (xy_f),
    .v  (xy_v),
    .h  (xy_h),
    .ok (xy_ok)
  );

  // FSM state register
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk27M or negedge rst) begin
    if (!rst) state_q <= ST_SEARCH;
    else      state_q <= state_d;
  end

  // Output, counter and lock registers
  always_ff @(posedge clk27M or negedge rst) begin
    if (!rst) r_q <= '0;
    else      r_q <= r_d;
  end

  // Preamble search, XY handling, active capture and lock tracking
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    r_d         = r_q;
    r_d.pix_valid = 1'b0;
    r_d.sav_pulse = 1'b0;
    r_d.eav_pulse = 1'b0;
    r_d.xy_err    = 1'b0;
    r_d.line_err  = 1'b0;
    code_ok     = 1'b0;
    seq_bad     = 1'b0;
    ff_abort    = 1'b0;

    unique case (state_q)
      ST_SEARCH: begin
        if (bus.din == PRE_FF) state_d = ST_P1;
      end

      ST_P1: begin
        if      (bus.din == PRE_00) state_d = ST_P2;
        else if (bus.din == PRE_FF) state_d = ST_P1;
        else                        state_d = ST_SEARCH;
      end

      ST_P2: begin
        if      (bus.din == PRE_00) state_d = ST_P3;
        else if (bus.din == PRE_FF) state_d = ST_P1;
        else                        state_d = ST_SEARCH;
      end

      ST_P3: begin
        state_d = ST_SEARCH;
        if (xy_ok) begin
          code_ok       = 1'b1;
          seq_bad       = r_q.have_code && (r_q.last_h == xy_h);
          r_d.field     = xy_f;
          r_d.vblank    = xy_v;
          r_d.hblank    = xy_h;
          r_d.have_code = 1'b1;
          r_d.last_h    = xy_h;
          if (xy_h) begin
            // EAV: count lines within a field, restart on field change
            r_d.eav_pulse = 1'b1;
            if (xy_f != r_q.field)            r_d.line_cnt = '0;
            else if (r_q.line_cnt != LINE_MAX) r_d.line_cnt = r_q.line_cnt + 10'd1;
          end else begin
            // SAV: start the active region
            r_d.sav_pulse  = 1'b1;
            r_d.sample_cnt = '0;
            r_d.act_idx    = '0;
            state_d        = ST_ACTIVE;
          end
        end else begin
          r_d.xy_err = 1'b1;
        end
      end

      ST_ACTIVE: begin
        if (bus.din == PRE_FF) begin
          // A preamble inside the active region truncates the line
          ff_abort = 1'b1;
          state_d  = ST_P1;
        end else begin
          r_d.pix_data   = bus.din;
          r_d.pix_valid  = ~r_q.vblank;
          r_d.sample_cnt = r_q.act_idx;
          r_d.act_idx    = r_q.act_idx + 11'd1;
          if (r_q.act_idx == LAST_IDX) state_d = ST_SEARCH;
        end
      end

      default: state_d = ST_SEARCH;
    endcase

    r_d.line_err = seq_bad | ff_abort;

    // Any error drops lock at once; well-ordered codes build it back up
    if (r_d.xy_err || r_d.line_err) begin
      r_d.lock_cnt = '0;
      r_d.locked   = 1'b0;
    end else if (code_ok) begin
      if (r_q.lock_cnt != LOCK_MAX) r_d.lock_cnt = r_q.lock_cnt + LOCK_ONE;
      if (r_q.lock_cnt >= LOCK_PRE) r_d.locked = 1'b1;
    end
  end

  assign bus.pix_data   = r_q.pix_data;
  assign bus.pix_valid  = r_q.pix_valid;
  assign bus.sample_cnt = r_q.sample_cnt;
  assign bus.line_cnt   = r_q.line_cnt;
  assign bus.field      = r_q.field;
  assign bus.vblank     = r_q.vblank;
  assign bus.hblank     = r_q.hblank;
  assign bus.sav_pulse  = r_q.sav_pulse;
  assign bus.eav_pulse  = r_q.eav_pulse;
  assign bus.xy_err     = r_q.xy_err;
  assign bus.line_err   = r_q.line_err;
  assign bus.locked     = r_q.locked;

endmodule

// File: tb/tb_ccir656_rx.sv
// Self-checking bench for ccir656_rx: directed lines, a table of XY codes
// and randomized streams, all compared byte by byte against a stream model.
module tb_ccir656_rx;

  localparam int NACT       = 1440;
  localparam int LOCK_LINES = 2;
  localparam int LOCK_CODES = 2 * LOCK_LINES;

  logic clk27M = 1'b0;
  logic rst    = 1'b1;

  ccir656_rx_if bus();

  ccir656_rx #(
    .ACTIVE_SAMPLES (NACT),
    .LOCK_LINES     (LOCK_LINES)
  ) dut (
    .clk27M (clk27M),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk27M = ~clk27M;

  int n_checks = 0;
  int n_pass   = 0;

  // Legal XY codes indexed by {F,V,H}
  logic [7:0] ref_xy [8] = '{8'h80, 8'h9D, 8'hAB, 8'hB6, 8'hC7, 8'hDA, 8'hEC, 8'hF1};

  // Stream model state
  logic [7:0] m_hist [$];
  bit         m_active;
  int         m_idx;
  bit         m_f, m_v, m_h;
  int         m_line;
  bit         m_have, m_last_h;
  int         m_good;
  bit         m_locked;
  bit         m_sav, m_eav, m_xyerr, m_lineerr, m_pv;
  logic [7:0] m_pd;
  int         m_sc;

  // Observed event counters for the directed tests
  int cnt_valid, cnt_sav, cnt_eav, cnt_xyerr, cnt_lineerr;

  typedef struct {
    logic [7:0] xy;
    logic [2:0] exp_pulse;  // {sav, eav, xy_err}
    logic [2:0] exp_fvh;
  } xy_vec_t;

  xy_vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] ramp(input int i);
    return 8'((i % 254) + 1);
  endfunction

  function automatic void model_reset();
    m_hist.delete();
    m_active = 0; m_idx = 0;
    m_f = 0; m_v = 0; m_h = 0; m_line = 0;
    m_have = 0; m_last_h = 0; m_good = 0; m_locked = 0;
    m_sav = 0; m_eav = 0; m_xyerr = 0; m_lineerr = 0; m_pv = 0;
    m_pd = 0; m_sc = 0;
  endfunction

  // One received byte: preamble recognised by the last three bytes seen
  // outside the active region; codes looked up in the legal code list.
  function automatic void model_step(input logic [7:0] b);
    int  code;
    int  n;
    bit  f, v, h, bad;
    m_sav = 0; m_eav = 0; m_xyerr = 0; m_lineerr = 0; m_pv = 0;
    n = m_hist.size();
    if (m_active) begin
      if (b == 8'hFF) begin
        m_lineerr = 1; m_active = 0; m_good = 0; m_locked = 0;
        m_hist.delete(); m_hist.push_back(b);
      end else begin
        m_pd = b; m_pv = !m_v; m_sc = m_idx; m_idx++;
        if (m_idx == NACT) begin m_active = 0; m_hist.delete(); end
      end
    end else if (n >= 3 && m_hist[n-3] == 8'hFF && m_hist[n-2] == 8'h00 && m_hist[n-1] == 8'h00) begin
      m_hist.delete();
      code = -1;
      for (int i = 0; i < 8; i++) if (ref_xy[i] == b) code = i;
      if (code < 0) begin
        m_xyerr = 1; m_good = 0; m_locked = 0;
      end else begin
        f = code[2]; v = code[1]; h = code[0];
        bad = m_have && (m_last_h == h);
        if (h) begin
          m_eav = 1;
          if (f != m_f) m_line = 0;
          else if (m_line < 1023) m_line++;
        end else begin
          m_sav = 1; m_active = 1; m_idx = 0; m_sc = 0;
        end
        m_f = f; m_v = v; m_h = h; m_have = 1; m_last_h = h;
        if (bad) begin
          m_lineerr = 1; m_good = 0; m_locked = 0;
        end else begin
          m_good++;
          if (m_good >= LOCK_CODES) m_locked = 1;
        end
      end
    end else begin
      m_hist.push_back(b);
      if (m_hist.size() > 3) void'(m_hist.pop_front());
    end
  endfunction

  function automatic logic [63:0] dut_outs();
    return {bus.pix_data, bus.pix_valid, bus.sample_cnt, bus.line_cnt, bus.field, bus.vblank,
            bus.hblank, bus.sav_pulse, bus.eav_pulse, bus.xy_err, bus.line_err, bus.locked};
  endfunction

  // Drive one byte, let the DUT sample it, then compare every output
  task automatic send_byte(input logic [7:0] b);
    bus.din = b;
    @(posedge clk27M);
    #1;
    model_step(b);
    check("pix", {bus.pix_valid, bus.pix_data, bus.sample_cnt}, {m_pv, m_pd, 11'(m_sc)});
    check("flags", {bus.field, bus.vblank, bus.hblank, bus.line_cnt}, {m_f, m_v, m_h, 10'(m_line)});
    check("pulses", {bus.sav_pulse, bus.eav_pulse, bus.xy_err, bus.line_err}, {m_sav, m_eav, m_xyerr, m_lineerr});
    check("locked", 64'(bus.locked), 64'(m_locked));
    if (bus.pix_valid) cnt_valid++;
    if (bus.sav_pulse) cnt_sav++;
    if (bus.eav_pulse) cnt_eav++;
    if (bus.xy_err)    cnt_xyerr++;
    if (bus.line_err)  cnt_lineerr++;
  endtask

  task automatic clr_counts();
    cnt_valid = 0; cnt_sav = 0; cnt_eav = 0; cnt_xyerr = 0; cnt_lineerr = 0;
  endtask

  task automatic send_code(input logic [7:0] xy);
    send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00); send_byte(xy);
  endtask

  task automatic send_blank(input int pairs);
    for (int i = 0; i < pairs; i++) begin send_byte(8'h80); send_byte(8'h10); end
  endtask

  task automatic send_active(input int n, input bit rnd, input int ff_at);
    for (int i = 0; i < n; i++) begin
      if (i == ff_at)  send_byte(8'hFF);
      else if (rnd)    send_byte(8'($urandom_range(0, 254)));
      else             send_byte(ramp(i));
    end
  endtask

  // Hold rst low for three cycles; outputs must clear asynchronously
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("reset_async", dut_outs(), 64'd0);
    repeat (3) @(posedge clk27M);
    #1;
    check("reset_hold", dut_outs(), 64'd0);
    model_reset();
    rst = 1'b1;
  endtask

  task automatic rand_line();
    int r, f, v, nb, ffpos;
    logic [7:0] eav, sav;
    r   = $urandom_range(0, 9);
    f   = $urandom_range(0, 1);
    v   = $urandom_range(0, 1);
    eav = ref_xy[f*4 + v*2 + 1];
    sav = ref_xy[f*4 + v*2];
    if (r == 0) eav = 8'($urandom_range(0, 255));
    send_code(eav);
    nb = $urandom_range(4, 40);
    for (int i = 0; i < nb; i++) send_byte(8'($urandom_range(0, 254)));
    send_code((r == 1) ? eav : sav);
    ffpos = (r == 2) ? $urandom_range(0, NACT - 1) : -1;
    send_active(NACT, 1'b1, ffpos);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vecs = '{
      '{8'h80, 3'b100, 3'b000}, '{8'h9D, 3'b010, 3'b001},
      '{8'hAB, 3'b100, 3'b010}, '{8'hB6, 3'b010, 3'b011},
      '{8'hC7, 3'b100, 3'b100}, '{8'hDA, 3'b010, 3'b101},
      '{8'hEC, 3'b100, 3'b110}, '{8'hF1, 3'b010, 3'b111},
      '{8'h81, 3'b001, 3'b111}, '{8'h1D, 3'b001, 3'b111},
      '{8'hF0, 3'b001, 3'b111}, '{8'hDB, 3'b001, 3'b111}
    };
    bus.din = 8'h00;
    model_reset();
    do_reset();

    // 1: reset in the middle of an active line discards the rest of it
    send_code(8'h9D); send_blank(8); send_code(8'h80);
    send_active(300, 1'b0, -1);
    do_reset();
    clr_counts();
    send_active(500, 1'b0, -1);
    check("t1_no_valid_after_reset", 64'(cnt_valid), 64'd0);

    // 2: clean line, ramp data
    send_code(8'h9D);
    check("t2_eav_pulse", 64'(bus.eav_pulse), 64'd1);
    send_blank(208);
    send_code(8'h80);
    check("t2_sav_pulse", 64'(bus.sav_pulse), 64'd1);
    clr_counts();
    send_active(NACT, 1'b0, -1);
    check("t2_valid_count", 64'(cnt_valid), 64'(NACT));
    check("t2_last_index", 64'(bus.sample_cnt), 64'(NACT - 1));
    check("t2_last_data", 64'(bus.pix_data), 64'(ramp(NACT - 1)));

    // 3: corrupted SAV
    send_code(8'h9D); send_blank(208);
    clr_counts();
    send_code(8'h81);
    check("t3_xy_err", 64'(bus.xy_err), 64'd1);
    send_active(NACT, 1'b0, -1);
    check("t3_no_sav", 64'(cnt_sav), 64'd0);
    check("t3_no_valid", 64'(cnt_valid), 64'd0);
    check("t3_unlocked", 64'(bus.locked), 64'd0);

    // 4: line counter across a field change, V=1 suppresses pix_valid
    do_reset();
    send_code(8'hDA);
    check("t4_line_f1", 64'({bus.field, bus.line_cnt}), 64'({1'b1, 10'd0}));
    send_blank(4); send_code(8'hC7); send_active(NACT, 1'b1, -1);
    send_code(8'h9D);
    check("t4_line_0", 64'({bus.field, bus.line_cnt}), 64'({1'b0, 10'd0}));
    send_blank(4); send_code(8'h80); send_active(NACT, 1'b1, -1);
    send_code(8'h9D);
    check("t4_line_1", 64'(bus.line_cnt), 64'd1);
    send_blank(4); send_code(8'h80); send_active(NACT, 1'b1, -1);
    send_code(8'hDA);
    check("t4_field_change", 64'({bus.field, bus.line_cnt}), 64'({1'b1, 10'd0}));
    send_blank(4);
    send_code(8'hAB);
    clr_counts();
    send_active(NACT, 1'b0, -1);
    check("t4_vblank_no_valid", 64'(cnt_valid), 64'd0);
    check("t4_vblank_flag", 64'(bus.vblank), 64'd1);

    // 6: lock after four well-ordered codes, lost on a double EAV
    do_reset();
    send_code(8'h9D); send_blank(4); send_code(8'h80); send_active(NACT, 1'b1, -1);
    send_code(8'h9D); send_blank(4);
    check("t6_lock_low_3rd", 64'(bus.locked), 64'd0);
    send_code(8'h80);
    check("t6_lock_rise_4th", 64'(bus.locked), 64'd1);
    send_active(NACT, 1'b1, -1);
    send_code(8'h9D); send_blank(4);
    send_code(8'h9D);
    check("t6_double_eav", 64'({bus.eav_pulse, bus.line_err, bus.locked}), 64'(3'b110));

    // 5: FF inside the active region truncates the line
    do_reset();
    send_code(8'h9D); send_blank(4); send_code(8'h80); send_active(NACT, 1'b1, -1);
    send_code(8'h9D); send_blank(4); send_code(8'h80);
    clr_counts();
    send_active(700, 1'b0, -1);
    check("t5_valid_700", 64'(cnt_valid), 64'd700);
    send_byte(8'hFF);
    check("t5_line_err", 64'({bus.line_err, bus.locked, bus.pix_valid}), 64'(3'b100));
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h9D);
    check("t5_eav_after_ff", 64'(bus.eav_pulse), 64'd1);

    // Table of XY codes applied after a clean reset
    do_reset();
    foreach (vecs[i]) begin
      send_code(vecs[i].xy);
      check("tbl_pulses", 64'({bus.sav_pulse, bus.eav_pulse, bus.xy_err}), 64'(vecs[i].exp_pulse));
      check("tbl_fvh", 64'({bus.field, bus.vblank, bus.hblank}), 64'(vecs[i].exp_fvh));
      if (vecs[i].exp_pulse[2]) send_active(NACT, 1'b1, -1);
    end

    // Preamble variants: repeated FF, restarted preamble, 00 as XY
    send_byte(8'hFF); send_code(8'h80);
    check("pre_ff_ff", 64'(bus.sav_pulse), 64'd1);
    send_active(NACT, 1'b1, -1);
    send_byte(8'hFF); send_byte(8'h00); send_code(8'h9D);
    check("pre_restart", 64'(bus.eav_pulse), 64'd1);
    send_code(8'h00);
    check("pre_xy_zero", 64'(bus.xy_err), 64'd1);

    // Randomized lines with occasional corruption
    do_reset();
    for (int l = 0; l < 12; l++) rand_line();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
